// File: rtl/step_counter_ctrl_if.sv
// Command/config/status bundle between a host agent and step_counter_ctrl.
// Build option: STEP_CTRL_DOWN_EN adds cfg_down for down-counting.
interface step_counter_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cfg_start;
    logic [STEP_W-1:0] cfg_step;
    logic [WIDTH-1:0]  cfg_limit;
    logic              cfg_wrap;
`ifdef STEP_CTRL_DOWN_EN
    logic              cfg_down;
`endif
    logic [WIDTH-1:0]  count_out;
    logic              busy;
    logic              done;
    logic              wrapped;

    modport master (
        output cmd_valid, cmd_op, cfg_start, cfg_step, cfg_limit, cfg_wrap,
`ifdef STEP_CTRL_DOWN_EN
        output cfg_down,
`endif
        input  cmd_ready, count_out, busy, done, wrapped
    );

    modport slave (
        input  cmd_valid, cmd_op, cfg_start, cfg_step, cfg_limit, cfg_wrap,
`ifdef STEP_CTRL_DOWN_EN
        input  cfg_down,
`endif
        output cmd_ready, count_out, busy, done, wrapped
    );
endinterface

// File: rtl/step_counter_ctrl.sv
// Command-driven programmable step counter (START/PAUSE/RESUME/STOP, wrap or stop at limit).
// Build option: STEP_CTRL_DOWN_EN enables down-counting selected by cfg_down at START.
module step_counter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic clk,
    input  logic rstn,
    step_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_PAUSE  = 2'b01,
        OP_RESUME = 2'b10,
        OP_STOP   = 2'b11
    } op_e;

    state_e            state_reg;
    logic [WIDTH-1:0]  count_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              wrapped_reg;
    logic              ready_reg;
    logic [WIDTH-1:0]  start_reg;
    logic [STEP_W-1:0] step_reg;
    logic [WIDTH-1:0]  limit_reg;
    logic              wrap_reg;

    logic              accept;
    logic [WIDTH:0]    step_ext;
    logic [WIDTH:0]    sum;
    logic              up_term;
    logic [WIDTH-1:0]  next_val;
    logic              terminal;
    logic              start_invalid;
    logic [STEP_W-1:0] cfg_step_eff;

    assign accept       = bus.cmd_valid && ready_reg;
    assign step_ext     = {{(WIDTH+1-STEP_W){1'b0}}, step_reg};
    assign sum          = {1'b0, count_reg} + step_ext;
    assign up_term      = sum > {1'b0, limit_reg};
    // A zero step would stall forever, so it is promoted to 1.
    assign cfg_step_eff = (bus.cfg_step == '0) ? STEP_W'(1) : bus.cfg_step;

`ifdef STEP_CTRL_DOWN_EN
    logic           down_reg;
    logic [WIDTH:0] diff;
    logic           down_term;

    assign diff          = {1'b0, count_reg} - step_ext;
    assign down_term     = diff[WIDTH] || (diff[WIDTH-1:0] < limit_reg);
    assign terminal      = down_reg ? down_term : up_term;
    assign next_val      = down_reg ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    assign start_invalid = bus.cfg_down ? (bus.cfg_start < bus.cfg_limit)
                                        : (bus.cfg_start > bus.cfg_limit);
`else
    assign terminal      = up_term;
    assign next_val      = sum[WIDTH-1:0];
    assign start_invalid = bus.cfg_start > bus.cfg_limit;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
            ready_reg   <= 1'b1;
            start_reg   <= '0;
            step_reg    <= '0;
            limit_reg   <= '0;
            wrap_reg    <= 1'b0;
`ifdef STEP_CTRL_DOWN_EN
            down_reg    <= 1'b0;
`endif
        end else begin
            done_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
            if (accept && bus.cmd_op == OP_START) begin
                start_reg <= bus.cfg_start;
                step_reg  <= cfg_step_eff;
                limit_reg <= bus.cfg_limit;
                wrap_reg  <= bus.cfg_wrap;
`ifdef STEP_CTRL_DOWN_EN
                down_reg  <= bus.cfg_down;
`endif
                if (start_invalid) begin
                    count_reg <= bus.cfg_limit;
                    state_reg <= S_DONE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                    done_reg  <= 1'b1;
                end else begin
                    count_reg <= bus.cfg_start;
                    state_reg <= S_RUN;
                    busy_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    S_RUN: begin
                        // Legal commands take priority over the increment.
                        if (accept && bus.cmd_op == OP_PAUSE) begin
                            state_reg <= S_PAUSE;
                        end else if (accept && bus.cmd_op == OP_STOP) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end else if (terminal) begin
                            if (wrap_reg) begin
                                count_reg   <= start_reg;
                                wrapped_reg <= 1'b1;
                            end else begin
                                count_reg <= limit_reg;
                                state_reg <= S_DONE;
                                busy_reg  <= 1'b0;
                                ready_reg <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            count_reg <= next_val;
                        end
                    end
                    S_PAUSE: begin
                        if (accept && bus.cmd_op == OP_RESUME) begin
                            state_reg <= S_RUN;
                        end else if (accept && bus.cmd_op == OP_STOP) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                        ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready = ready_reg;
    assign bus.count_out = count_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.wrapped   = wrapped_reg;
endmodule

// File: tb/tb_step_counter_ctrl.sv
// Directed bench for step_counter_ctrl: per-cycle expectations queued at drive time, popped after each edge.
module tb_step_counter_ctrl;
    localparam logic [1:0] START  = 2'b00;
    localparam logic [1:0] PAUSE  = 2'b01;
    localparam logic [1:0] RESUME = 2'b10;
    localparam logic [1:0] STOP   = 2'b11;

    typedef struct {
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       wrapped;
        logic       ready;
        string      tag;
    } exp_t;

    logic  clk;
    logic  rstn;
    int    checks;
    int    failures;
    exp_t  sb[$];

    step_counter_ctrl_if #(.WIDTH(8), .STEP_W(4)) bus ();

    step_counter_ctrl #(.WIDTH(8), .STEP_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.tag, ".count"},   32'(bus.count_out), 32'(e.count));
        chk({e.tag, ".busy"},    32'(bus.busy),      32'(e.busy));
        chk({e.tag, ".done"},    32'(bus.done),      32'(e.done));
        chk({e.tag, ".wrapped"}, 32'(bus.wrapped),   32'(e.wrapped));
        chk({e.tag, ".ready"},   32'(bus.cmd_ready), 32'(e.ready));
        $display("step %-14s count=%02h busy=%0b done=%0b wrapped=%0b ready=%0b",
                 e.tag, bus.count_out, bus.busy, bus.done, bus.wrapped, bus.cmd_ready);
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
    task automatic step(input logic v, input logic [1:0] op,
                        input logic [7:0] s, input logic [3:0] st, input logic [7:0] lim, input logic w,
                        input logic [7:0] ec, input logic eb, input logic ed, input logic ew, input logic er,
                        input string tag);
        exp_t e;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cfg_start = s;
        bus.cfg_step  = st;
        bus.cfg_limit = lim;
        bus.cfg_wrap  = w;
        e.count = ec; e.busy = eb; e.done = ed; e.wrapped = ew; e.ready = er; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check_outputs(sb.pop_front());
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] ec, input logic eb,
                       input logic ed, input logic ew, input logic er, input string tag);
        step(1'b1, op, 8'h00, 4'h0, 8'h00, 1'b0, ec, eb, ed, ew, er, tag);
    endtask

    task automatic idle(input logic [7:0] ec, input logic eb, input logic ed,
                        input logic ew, input logic er, input string tag);
        step(1'b0, START, 8'h00, 4'h0, 8'h00, 1'b0, ec, eb, ed, ew, er, tag);
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        rstn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = START;
        bus.cfg_start = '0;
        bus.cfg_step  = '0;
        bus.cfg_limit = '0;
        bus.cfg_wrap  = 1'b0;
`ifdef STEP_CTRL_DOWN_EN
        bus.cfg_down  = 1'b0;
`endif
        #12;
        e.count = 8'h00; e.busy = 0; e.done = 0; e.wrapped = 0; e.ready = 1; e.tag = "reset";
        check_outputs(e);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Stop mode: 1,3,5,7,9 then DONE holding 9
        step(1, START, 8'd1, 4'd2, 8'd9, 1'b0, 8'd1, 1, 0, 0, 1, "stop.s0");
        idle(8'd3, 1, 0, 0, 1, "stop.c3");
        idle(8'd5, 1, 0, 0, 1, "stop.c5");
        idle(8'd7, 1, 0, 0, 1, "stop.c7");
        idle(8'd9, 1, 0, 0, 1, "stop.c9");
        idle(8'd9, 0, 1, 0, 0, "stop.done");
        idle(8'd9, 0, 0, 0, 1, "stop.idle");

        // Wrap mode near the top of the 8-bit range
        step(1, START, 8'hF0, 4'd8, 8'hFE, 1'b1, 8'hF0, 1, 0, 0, 1, "wrap.s0");
        idle(8'hF8, 1, 0, 0, 1, "wrap.f8");
        idle(8'hF0, 1, 0, 1, 1, "wrap.reload");
        idle(8'hF8, 1, 0, 0, 1, "wrap.f8b");
        cmd(STOP, 8'hF8, 0, 0, 0, 1, "wrap.stop");

        // Pause / resume / stop
        step(1, START, 8'd5, 4'd2, 8'h40, 1'b0, 8'd5, 1, 0, 0, 1, "pr.s0");
        cmd(PAUSE, 8'd5, 1, 0, 0, 1, "pr.pause");
        idle(8'd5, 1, 0, 0, 1, "pr.hold1");
        idle(8'd5, 1, 0, 0, 1, "pr.hold2");
        idle(8'd5, 1, 0, 0, 1, "pr.hold3");
        cmd(RESUME, 8'd5, 1, 0, 0, 1, "pr.resume");
        idle(8'd7, 1, 0, 0, 1, "pr.inc");
        cmd(STOP, 8'd7, 0, 0, 0, 1, "pr.stop");
        idle(8'd7, 0, 0, 0, 1, "pr.idle");

        // Zero step promoted to 1; START during DONE must be refused
        step(1, START, 8'd3, 4'd0, 8'd5, 1'b0, 8'd3, 1, 0, 0, 1, "z.s0");
        idle(8'd4, 1, 0, 0, 1, "z.c4");
        idle(8'd5, 1, 0, 0, 1, "z.c5");
        idle(8'd5, 0, 1, 0, 0, "z.done");
        step(1, START, 8'd10, 4'd1, 8'h20, 1'b0, 8'd5, 0, 0, 0, 1, "z.refused");

        // Invalid config: start above limit clamps and finishes at once
        step(1, START, 8'd10, 4'd1, 8'd4, 1'b0, 8'd4, 0, 1, 0, 0, "inv.done");
        idle(8'd4, 0, 0, 0, 1, "inv.idle");

        // Illegal commands are consumed without effect
        cmd(RESUME, 8'd4, 0, 0, 0, 1, "ill.resume");
        idle(8'd4, 0, 0, 0, 1, "ill.idle");
        step(1, START, 8'h20, 4'd1, 8'h30, 1'b0, 8'h20, 1, 0, 0, 1, "ill.s0");
        idle(8'h21, 1, 0, 0, 1, "ill.c21");
        cmd(PAUSE, 8'h21, 1, 0, 0, 1, "ill.pause");
        cmd(PAUSE, 8'h21, 1, 0, 0, 1, "ill.pause2");
        idle(8'h21, 1, 0, 0, 1, "ill.held");
        cmd(RESUME, 8'h21, 1, 0, 0, 1, "ill.resume2");
        idle(8'h22, 1, 0, 0, 1, "ill.c22");
        idle(8'h23, 1, 0, 0, 1, "ill.c23");
        idle(8'h24, 1, 0, 0, 1, "ill.c24");

        // Asynchronous reset mid-RUN at count 0x24
        #3 rstn = 1'b0;
        #1;
        e.count = 8'h00; e.busy = 0; e.done = 0; e.wrapped = 0; e.ready = 1; e.tag = "arst";
        check_outputs(e);
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(8'h00, 0, 0, 0, 1, "arst.rel");
        idle(8'h00, 0, 0, 0, 1, "arst.idle");
        step(1, START, 8'd7, 4'd1, 8'd8, 1'b0, 8'd7, 1, 0, 0, 1, "post.s0");
        idle(8'd8, 1, 0, 0, 1, "post.c8");
        idle(8'd8, 0, 1, 0, 0, "post.done");
        idle(8'd8, 0, 0, 0, 1, "post.idle");

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/step_counter_ctrl.md
Name: step_counter_ctrl

Overview:
Command-driven controller for a programmable step counter (start value, step, limit, wrap/stop mode). Accepts START/PAUSE/RESUME/STOP commands over a valid/ready handshake and sequences the count through an FSM. Reports busy, terminal-count and wrap events. Sits between a host/config agent and any logic that consumes a paced stepping count.

Parameters:
WIDTH, 8, count, start and limit width in bits
STEP_W, 4, step width in bits

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready; a command is accepted when cmd_valid && cmd_ready on a rising clk edge
cmd_op  in  2  00 START, 01 PAUSE, 10 RESUME, 11 STOP
cfg_start  in  WIDTH  start/reload value, sampled on START accept
cfg_step  in  STEP_W  increment, sampled on START accept
cfg_limit  in  WIDTH  terminal value, sampled on START accept
cfg_wrap  in  1  1 = reload at terminal, 0 = stop at terminal; sampled on START accept
count_out  out  WIDTH  current count, registered
busy  out  1  high in RUN or PAUSE
done  out  1  one-cycle pulse on the cycle the FSM is in DONE
wrapped  out  1  one-cycle pulse on the cycle after a wrap reload

Behaviour:
- Reset (rstn low, async): state IDLE, count_out=0, busy=0, done=0, wrapped=0, latched config=0. Takes effect immediately mid-operation; no command is pending after release.
- States: IDLE, RUN, PAUSE, DONE. cmd_ready=1 in IDLE/RUN/PAUSE, 0 in DONE. DONE lasts exactly one cycle, then IDLE.
- START (any state with ready): latch cfg_*; count_out<=cfg_start; next state RUN. cfg_step==0 is latched as 1. If cfg_start > cfg_limit: count_out<=cfg_limit, next state DONE.
- Latency: START accepted at edge N -> count_out=start after N; first increment at edge N+1.
- RUN, no accepted command: sum = count_out + step in WIDTH+1 bits (no native overflow).
  - sum <= limit: count_out<=sum[WIDTH-1:0].
  - sum > limit, wrap=1: count_out<=start, wrapped=1 next cycle, stay RUN.
  - sum > limit, wrap=0: count_out<=limit, next state DONE (done=1 that cycle).
- PAUSE accepted in RUN: no increment that cycle; count held; -> PAUSE. RESUME in PAUSE -> RUN; increments resume next edge.
- STOP in RUN/PAUSE: count held, -> IDLE, no done pulse.
- Accepted commands illegal for the current state (PAUSE in IDLE/PAUSE, RESUME in IDLE/RUN, STOP in IDLE) are consumed and ignored.
- Priority: accepted command beats same-cycle increment/terminal; START beats everything.
- cfg_* changes outside a START accept have no effect.

Optional Feature:
STEP_CTRL_DOWN_EN: defined -> extra input cfg_down (1 bit, sampled on START). When latched 1: counts down, diff = count_out - step with borrow; terminal when borrow or diff < limit; wrap reloads start, stop mode clamps to limit. Invalid-config check becomes cfg_start < cfg_limit. Undefined -> port absent, up-count only.

Test Plan:
- Reset mid-RUN (count=0x24), rstn low -> immediately count_out=0, busy=0, state IDLE; cmd_ready=1 after release.
- START start=1, step=2, limit=9, wrap=0 -> count 1,3,5,7,9; then done pulse 1 cycle with count=9; IDLE; busy drops with done.
- START start=0xF0, step=8, limit=0xFE, wrap=1 -> F0,F8, then reload F0 with wrapped pulse; no 8-bit overflow.
- RUN at count=5: PAUSE -> count stays 5 for 3 cycles; RESUME -> 7 next edge; STOP -> IDLE with count 7, no done.
- START with step=0, start=3, limit=5 -> steps by 1: 3,4,5, done. START with start=10, limit=4 -> count=4, done next cycle.
- RESUME issued in IDLE and PAUSE issued in PAUSE -> accepted (ready=1), no state/count change.
